network_mul_arbiter: RTL

NETWORK_MUL_ARBITER -- requirements
Module: network_mul_arbiter

---
 rtl/network_mul_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/network_mul_arbiter.sv
// Round-robin arbiter that shares one signed 16x16 multiplier among four requesters.
// Define NETWORK_MUL_ARBITER_OUTREG_EN to add a second output register (latency 2 instead of 1).
module network_mul_arbiter #(
   parameter logic [31:0] ID    = 32'd1,
   parameter int          N_REQ = 4
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [16*N_REQ-1:0]  req_a,
   input  logic [16*N_REQ-1:0]  req_b,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [31:0]          res_dout,
   output logic [1:0]           res_id,
   output logic [31:0]          op_count,
   output logic                 ap_idle
);

   logic        unused_id;
   logic [1:0]  ptr_q, ptr_d;
   logic        s1_valid_q, s1_valid_d;
   logic [31:0] s1_dout_q, s1_dout_d;
   logic [1:0]  s1_id_q, s1_id_d;
   logic [31:0] op_count_q, op_count_d;
   logic        found, grant, s1_adv;
   logic [1:0]  win_id, idx;
   logic signed [15:0] a_sel, b_sel;
   logic signed [31:0] prod;

   assign unused_id = ^ID;

   always_comb begin
      found  = 1'b0;
      win_id = 2'd0;
      idx    = 2'd0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            win_id = idx;
         end
      end
   end

   assign a_sel = req_a[16*win_id +: 16];
   assign b_sel = req_b[16*win_id +: 16];
   assign prod  = a_sel * b_sel;

`ifdef NETWORK_MUL_ARBITER_OUTREG_EN
   logic        s2_valid_q, s2_valid_d;
   logic [31:0] s2_dout_q, s2_dout_d;
   logic [1:0]  s2_id_q, s2_id_d;
   logic        s2_adv;

   // Stall ripples back one stage at a time: stage 1 may fill while stage 2 waits.
   assign s2_adv = !s2_valid_q || res_ready;
   assign s1_adv = !s1_valid_q || s2_adv;

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_dout_d  = s2_dout_q;
      s2_id_d    = s2_id_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_dout_d = s1_dout_q;
            s2_id_d   = s1_id_q;
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         s2_valid_q <= 1'b0;
         s2_dout_q  <= 32'd0;
         s2_id_q    <= 2'd0;
      end else begin
         s2_valid_q <= s2_valid_d;
         s2_dout_q  <= s2_dout_d;
         s2_id_q    <= s2_id_d;
      end
   end

   assign res_valid = s2_valid_q;
   assign res_dout  = s2_dout_q;
   assign res_id    = s2_id_q;
   assign ap_idle   = !((|req_valid) || s1_valid_q || s2_valid_q);
`else
   assign s1_adv    = !s1_valid_q || res_ready;
   assign res_valid = s1_valid_q;
   assign res_dout  = s1_dout_q;
   assign res_id    = s1_id_q;
   assign ap_idle   = !((|req_valid) || s1_valid_q);
`endif

   assign grant = found && s1_adv && !ap_rst;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = grant && (win_id == 2'(i));
      end
   end

   always_comb begin
      s1_valid_d = s1_adv ? grant : s1_valid_q;
      s1_dout_d  = grant ? prod : s1_dout_q;
      s1_id_d    = grant ? win_id : s1_id_q;
      op_count_d = op_count_q + 32'(grant);
      ptr_d      = grant ? win_id + 2'd1 : ptr_q;
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         ptr_q      <= 2'd0;
         s1_valid_q <= 1'b0;
         s1_dout_q  <= 32'd0;
         s1_id_q    <= 2'd0;
         op_count_q <= 32'd0;
      end else begin
         ptr_q      <= ptr_d;
         s1_valid_q <= s1_valid_d;
         s1_dout_q  <= s1_dout_d;
         s1_id_q    <= s1_id_d;
         op_count_q <= op_count_d;
      end
   end

   assign op_count = op_count_q;

endmodule
